// File: rtl/ids_word_matcher_pkg.sv
// Shared constants and types for the IDS word matcher.
// Holds register indices, parser state encoding, ring widths and the compare helper.
// No logic of its own; imported by the matcher top.
package ids_word_matcher_pkg;

    localparam int UDP_REG_ADDR_WIDTH  = 23;
    localparam int CPCI_NF2_DATA_WIDTH = 32;

    // Register word index within the block (addr[2:0]).
    localparam logic [2:0] IDX_PAT_HI    = 3'd0;
    localparam logic [2:0] IDX_PAT_LO    = 3'd1;
    localparam logic [2:0] IDX_PKT_CNT   = 3'd2;
    localparam logic [2:0] IDX_MATCH_CNT = 3'd3;
    localparam logic [2:0] IDX_CTRL      = 3'd4;
    localparam logic [2:0] IDX_MASK_HI   = 3'd5;
    localparam logic [2:0] IDX_MASK_LO   = 3'd6;

    // Returned for indices with no register behind them.
    localparam logic [CPCI_NF2_DATA_WIDTH-1:0] UNMAPPED_RD_DATA = 32'hDEADBEEF;

    typedef enum logic {
        HDR     = 1'b0,
        PAYLOAD = 1'b1
    } parse_state_e;

    // Masked equality: bits cleared in mask never cause a miss.
    function automatic logic word_hit(input logic [63:0] word,
                                      input logic [63:0] pattern,
                                      input logic [63:0] mask);
        return ((word ^ pattern) & mask) == 64'd0;
    endfunction

endpackage

// File: rtl/ids_word_matcher_if.sv
// Packet stream bundle: data, ctrl, write strobe and reverse ready.
// master drives data/ctrl/wr and samples rdy; slave is the mirror image.
// Pure wiring, no latency or storage.
interface ids_word_matcher_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] data;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic                  wr;
    logic                  rdy;

    modport master (output data, output ctrl, output wr, input rdy);
    modport slave  (input data, input ctrl, input wr, output rdy);
endinterface

// File: rtl/ids_fallthrough_fifo.sv
// Small circular FIFO; dout shows the head entry whenever empty is low.
// Latency: a word written on one edge is readable in the following cycle.
// Backpressure: writes while full and reads while empty are dropped; nearly_full = at most one free slot.
module ids_fallthrough_fifo #(
    parameter int WIDTH      = 72,
    parameter int DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             nearly_full
);
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] CNT_FULL = (DEPTH_BITS + 1)'(DEPTH);
    localparam logic [DEPTH_BITS:0] CNT_NF   = (DEPTH_BITS + 1)'(DEPTH - 1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BITS:0]   count_q, count_d;
    logic                  do_wr, do_rd;

    assign empty       = (count_q == '0);
    assign full        = (count_q == CNT_FULL);
    assign nearly_full = (count_q >= CNT_NF);
    assign dout        = mem[rd_ptr_q];

    always_comb begin
        do_wr    = wr_en && !full;
        do_rd    = rd_en && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_wr && !do_rd)      count_d = count_q + 1'b1;
        else if (!do_wr && do_rd) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/ids_word_matcher.sv
// Forwards packets unchanged through a 4-entry FIFO, counting packets and packets with a 64-bit pattern hit.
// Latency: 2 cycles in_if.wr -> out_if.wr (FIFO write, then registered pop); ring outputs 1 cycle.
// Backpressure: in_if.rdy drops with one FIFO slot left; a word pops only while out_if.rdy is high.
// Ports: clk/reset (sync, active high), in_if (slave stream), out_if (master stream), reg_*_in/out UDP register ring.
// Build option IDS_MASK_EN adds mask_hi/mask_lo registers (indices 5/6) for a masked compare.
module ids_word_matcher
    import ids_word_matcher_pkg::*;
#(
    parameter int DATA_WIDTH        = 64,
    parameter int CTRL_WIDTH        = DATA_WIDTH / 8,
    parameter int UDP_REG_SRC_WIDTH = 2,
    parameter logic [UDP_REG_ADDR_WIDTH-1:0] BLOCK_ADDR = 23'h000100,
    parameter int FIFO_DEPTH_BITS   = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    ids_word_matcher_if.slave              in_if,
    ids_word_matcher_if.master             out_if,
    input  logic                           reg_req_in,
    input  logic                           reg_ack_in,
    input  logic                           reg_rd_wr_L_in,
    input  logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in,
    input  logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_in,
    input  logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_in,
    output logic                           reg_req_out,
    output logic                           reg_ack_out,
    output logic                           reg_rd_wr_L_out,
    output logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out,
    output logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_out,
    output logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_out
);
    localparam int FIFO_W = DATA_WIDTH + CTRL_WIDTH;

    // ---------------- datapath FIFO and output register ----------------
    logic              fifo_rd, fifo_empty, fifo_full, fifo_nearly_full, in_accept;
    logic [FIFO_W-1:0] fifo_dout;

    assign in_accept = in_if.wr && !fifo_full;
    assign in_if.rdy = !fifo_nearly_full;
    assign fifo_rd   = !fifo_empty && out_if.rdy;

    ids_fallthrough_fifo #(.WIDTH(FIFO_W), .DEPTH_BITS(FIFO_DEPTH_BITS)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .din         ({in_if.ctrl, in_if.data}),
        .wr_en       (in_if.wr),
        .rd_en       (fifo_rd),
        .dout        (fifo_dout),
        .empty       (fifo_empty),
        .full        (fifo_full),
        .nearly_full (fifo_nearly_full)
    );

    logic                  out_wr_q, out_wr_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;

    assign out_if.wr   = out_wr_q;
    assign out_if.data = out_data_q;
    assign out_if.ctrl = out_ctrl_q;

    // ---------------- parser, counters and registers ----------------
    parse_state_e state_q, state_d;
    logic         pkt_hit_q, pkt_hit_d, word_match;
    logic [31:0]  pkt_cnt_q, pkt_cnt_d, match_cnt_q, match_cnt_d;
    logic [31:0]  pat_hi_q, pat_hi_d, pat_lo_q, pat_lo_d, rd_val;
    logic [63:0]  cmp_mask;
    logic         ring_hit, reg_wr;
    logic [2:0]   reg_idx;

`ifdef IDS_MASK_EN
    logic [31:0] mask_hi_q, mask_hi_d, mask_lo_q, mask_lo_d;
    assign cmp_mask = {mask_hi_q, mask_lo_q};
`else
    assign cmp_mask = '1;
`endif

    // Ring outputs are all registered.
    logic                           req_out_q, req_out_d, ack_out_q, ack_out_d, rdwr_out_q, rdwr_out_d;
    logic [UDP_REG_ADDR_WIDTH-1:0]  addr_out_q, addr_out_d;
    logic [CPCI_NF2_DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [UDP_REG_SRC_WIDTH-1:0]   src_out_q, src_out_d;

    assign reg_req_out     = req_out_q;
    assign reg_ack_out     = ack_out_q;
    assign reg_rd_wr_L_out = rdwr_out_q;
    assign reg_addr_out    = addr_out_q;
    assign reg_data_out    = data_out_q;
    assign reg_src_out     = src_out_q;

    // A request already acked upstream is passed on untouched even if it targets this block.
    assign ring_hit = reg_req_in && !reg_ack_in &&
                      (reg_addr_in[UDP_REG_ADDR_WIDTH-1:3] == BLOCK_ADDR[UDP_REG_ADDR_WIDTH-1:3]);
    assign reg_wr   = ring_hit && !reg_rd_wr_L_in;
    assign reg_idx  = reg_addr_in[2:0];

    always_comb begin
        rd_val = UNMAPPED_RD_DATA;
        case (reg_idx)
            IDX_PAT_HI:    rd_val = pat_hi_q;
            IDX_PAT_LO:    rd_val = pat_lo_q;
            IDX_PKT_CNT:   rd_val = pkt_cnt_q;
            IDX_MATCH_CNT: rd_val = match_cnt_q;
            IDX_CTRL:      rd_val = '0;
`ifdef IDS_MASK_EN
            IDX_MASK_HI:   rd_val = mask_hi_q;
            IDX_MASK_LO:   rd_val = mask_lo_q;
`endif
            default:       ;
        endcase
    end

    always_comb begin
        out_wr_d   = fifo_rd;
        out_data_d = out_data_q;
        out_ctrl_d = out_ctrl_q;
        if (fifo_rd) {out_ctrl_d, out_data_d} = fifo_dout;

        state_d     = state_q;
        pkt_hit_d   = pkt_hit_q;
        pkt_cnt_d   = pkt_cnt_q;
        match_cnt_d = match_cnt_q;
        pat_hi_d    = pat_hi_q;
        pat_lo_d    = pat_lo_q;
`ifdef IDS_MASK_EN
        mask_hi_d   = mask_hi_q;
        mask_lo_d   = mask_lo_q;
`endif
        word_match  = word_hit(in_if.data, {pat_hi_q, pat_lo_q}, cmp_mask);

        // Only words the FIFO actually took are parsed, so counts track the forwarded stream.
        if (in_accept) begin
            case (state_q)
                HDR: begin
                    if (in_if.ctrl == '0) begin
                        state_d   = PAYLOAD;
                        pkt_hit_d = word_match;
                    end
                end
                PAYLOAD: begin
                    pkt_hit_d = pkt_hit_q | word_match;
                    if (in_if.ctrl != '0) begin
                        state_d     = HDR;
                        pkt_cnt_d   = pkt_cnt_q + 32'd1;
                        match_cnt_d = match_cnt_q + {31'd0, pkt_hit_d};
                    end
                end
                default: state_d = HDR;
            endcase
        end

        // Applied after the parser so a clear overrides a same-cycle EOP increment.
        if (reg_wr) begin
            case (reg_idx)
                IDX_PAT_HI: pat_hi_d = reg_data_in;
                IDX_PAT_LO: pat_lo_d = reg_data_in;
                IDX_CTRL: begin
                    if (reg_data_in[0]) begin
                        pkt_cnt_d   = '0;
                        match_cnt_d = '0;
                    end
                end
`ifdef IDS_MASK_EN
                IDX_MASK_HI: mask_hi_d = reg_data_in;
                IDX_MASK_LO: mask_lo_d = reg_data_in;
`endif
                default: ;
            endcase
        end

        req_out_d  = reg_req_in;
        ack_out_d  = reg_ack_in || ring_hit;
        rdwr_out_d = reg_rd_wr_L_in;
        addr_out_d = reg_addr_in;
        src_out_d  = reg_src_in;
        data_out_d = (ring_hit && reg_rd_wr_L_in) ? rd_val : reg_data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_wr_q    <= 1'b0;
            out_data_q  <= '0;
            out_ctrl_q  <= '0;
            state_q     <= HDR;
            pkt_hit_q   <= 1'b0;
            pkt_cnt_q   <= '0;
            match_cnt_q <= '0;
            pat_hi_q    <= '0;
            pat_lo_q    <= '0;
`ifdef IDS_MASK_EN
            mask_hi_q   <= '1;
            mask_lo_q   <= '1;
`endif
            req_out_q   <= 1'b0;
            ack_out_q   <= 1'b0;
            rdwr_out_q  <= 1'b0;
            addr_out_q  <= '0;
            data_out_q  <= '0;
            src_out_q   <= '0;
        end else begin
            out_wr_q    <= out_wr_d;
            out_data_q  <= out_data_d;
            out_ctrl_q  <= out_ctrl_d;
            state_q     <= state_d;
            pkt_hit_q   <= pkt_hit_d;
            pkt_cnt_q   <= pkt_cnt_d;
            match_cnt_q <= match_cnt_d;
            pat_hi_q    <= pat_hi_d;
            pat_lo_q    <= pat_lo_d;
`ifdef IDS_MASK_EN
            mask_hi_q   <= mask_hi_d;
            mask_lo_q   <= mask_lo_d;
`endif
            req_out_q   <= req_out_d;
            ack_out_q   <= ack_out_d;
            rdwr_out_q  <= rdwr_out_d;
            addr_out_q  <= addr_out_d;
            data_out_q  <= data_out_d;
            src_out_q   <= src_out_d;
        end
    end

endmodule

// File: doc/ids_word_matcher.md
Name: ids_word_matcher

Overview:
- User data path stage directly downstream of the passthrough stage; consumes its out_data/out_ctrl/out_wr stream and register ring.
- Forwards every packet unchanged through a small internal FIFO.
- Compares each 64-bit payload word against a software-programmed pattern.
- Keeps packet and match counters that software reads over the UDP register ring.

Parameters:
- DATA_WIDTH, 64, datapath width.
- CTRL_WIDTH, DATA_WIDTH/8, ctrl width.
- UDP_REG_SRC_WIDTH, 2, register source tag width.
- BLOCK_ADDR, 23'h000100, register block base address; low 3 bits are the word index.
- FIFO_DEPTH_BITS, 2, log2 of internal FIFO depth (4 entries).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  DATA_WIDTH  upstream data.
- in_ctrl  in  CTRL_WIDTH  upstream ctrl; nonzero marks a module header or the last word.
- in_wr  in  1  upstream write strobe.
- in_rdy  out  1  this stage can accept a word.
- out_data  out  DATA_WIDTH  downstream data.
- out_ctrl  out  CTRL_WIDTH  downstream ctrl.
- out_wr  out  1  downstream write strobe.
- out_rdy  in  1  downstream ready.
- reg_req_in, reg_ack_in, reg_rd_wr_L_in  in  1 each  register ring inputs.
- reg_addr_in  in  `UDP_REG_ADDR_WIDTH (23)  ring address.
- reg_data_in  in  `CPCI_NF2_DATA_WIDTH (32)  ring data.
- reg_src_in  in  UDP_REG_SRC_WIDTH  ring source tag.
- reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out  out  same widths  ring outputs.

Behaviour:
- One clock domain, clk. reset is synchronous and active-high.
- Reset values: out_wr=0; all reg_*_out=0; counters=0; pattern=0; state=HDR; FIFO empty.
- in_rdy = !fifo_nearly_full; nearly_full means at most 1 free entry. A write while full is a protocol error and is ignored.
- Output handshake: out_wr=1 only when the FIFO is non-empty and out_rdy=1; each out_wr pops one word.
- Minimum word latency is 2 cycles from in_wr to out_wr. Data and ctrl pass bit-exact and in order.
- Parser FSM runs on accepted input words:
  - HDR: ctrl!=0 stays in HDR; ctrl==0 goes to PAYLOAD, clears pkt_hit and compares this word.
  - PAYLOAD: ctrl==0 compares and stays; ctrl!=0 is the EOP word, which is also compared. On EOP: pkt_count+=1, match_count+=pkt_hit_next, go to HDR.
- Compare: word == {pattern_hi, pattern_lo}; a hit sets pkt_hit. Each packet adds at most 1 to match_count.
- Counters are 32 bits and wrap from 0xFFFFFFFF to 0.
- Registers, idx = addr[2:0] when addr[22:3]==BLOCK_ADDR[22:3]:
  - 0 pattern_hi, RW.
  - 1 pattern_lo, RW.
  - 2 pkt_count, RO.
  - 3 match_count, RO.
  - 4 control, RW; bit0 writing 1 clears both counters (self-clearing, reads 0).
  - 5-7 read 0xDEADBEEF.
- Ring timing: all ring outputs are registered, 1-cycle latency.
  - If req_in && !ack_in && address matches: a read drives data_out=register value with ack_out=1; a write updates the register with ack_out=1.
  - Otherwise all ring signals are forwarded unchanged.
- A pattern write takes effect on the next compared word.
- Counter clear on the same cycle as an EOP increment: clear wins, giving result 0.
- Reset mid-packet: FSM returns to HDR and the FIFO is flushed; no partial counts.

Optional Feature:
- IDS_MASK_EN defined adds registers 5 mask_hi and 6 mask_lo (RW, reset all-ones).
  - Compare becomes (word & mask) == (pattern & mask).
  - Indices 5-6 then no longer read 0xDEADBEEF.
- Undefined: exact compare only; indices 5-6 read 0xDEADBEEF and writes to them are ignored.

Decomposition:
- Shared package holds:
  - Register index constants: IDX_PAT_HI=0, IDX_PAT_LO=1, IDX_PKT_CNT=2, IDX_MATCH_CNT=3, IDX_CTRL=4, IDX_MASK_HI=5, IDX_MASK_LO=6.
  - FSM state encoding: HDR=0, PAYLOAD=1.
  - The unmapped-read constant 0xDEADBEEF.
- One sub-module: ids_fallthrough_fifo, a parameterised width/depth FIFO with wr_en, rd_en, empty, full, nearly_full.

Test Plan:
- Write pattern 0x0011223344556677; send a packet of 1 header, 3 payload words with word 2 matching, and EOP -> pkt_count=1, match_count=1, output stream identical.
- Packet with 2 matching words -> match_count increments by exactly 1.
- out_rdy held 0 for 10 cycles during a packet -> in_rdy drops after 3 words, no loss or reorder, all words delivered after release.
- Preload pkt_count=0xFFFFFFFF (via 2^32-1 short packets in the fast-sim model), then one packet -> pkt_count=0.
- Read at BLOCK_ADDR+7 -> ack_out=1, data=0xDEADBEEF. Read at a non-matching address -> forwarded unchanged, 1-cycle delay.
- Write control=1 on the same cycle as an EOP -> both counters read 0. Assert reset mid-payload -> out_wr=0 next cycle, the next packet counts normally.
